// File: rtl/fft_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_iter_pkg
// Description : Shared types and helpers for the iterative FFT address
//               generator. Holds the in-place radix-2 DIT butterfly address
//               function (layer/butterfly -> A, B, twiddle index).
// Revision    : 1.0 - initial release
// ============================================================================
package fft_iter_pkg;

    localparam int LAYERS_DEF = 5;
    localparam int ADDR_WL    = LAYERS_DEF;

    // Full-width butterfly addresses; callers truncate to their own widths.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tw;
    } bfly_addr_t;

    // Ceiling log2, for sizing counters from element counts.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Butterfly b of layer lay: partners are span apart inside groups of
    // 2*span; the twiddle stride shrinks as the span grows.
    function automatic bfly_addr_t bfly_addr(
        input logic [31:0] lay,
        input logic [31:0] but,
        input logic [31:0] layers
    );
        logic [31:0] span;
        logic [31:0] grp;
        logic [31:0] pos;
        bfly_addr_t  res;
        span   = 32'd1 << lay;
        grp    = but >> lay;
        pos    = but & (span - 32'd1);
        res.a  = (grp << (lay + 32'd1)) | pos;
        res.b  = res.a + span;
        res.tw = pos << (layers - 32'd1 - lay);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_delay_line
// Description : DEPTH-stage {valid,data} shift register. Advances only when
//               en is high; clr (qualified by en) drops every valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_delay_line
    import fft_iter_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    // Valid bits: cleared on reset/clear, otherwise shifted one stage per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (en) begin
            if (clr) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end
    end

    // Payload shifts alongside the valid bits; its content is meaningless when invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (en) begin
            r_data[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_iter_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_iter_addr_gen
// Description : Converts iterative-FFT control strobes into in-place radix-2
//               DIT read/write addresses and twiddle indices. Write-back
//               addresses trail the read addresses by BUT_LATENCY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_iter_addr_gen
    import fft_iter_pkg::*;
#(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4,
    parameter int BUT_LATENCY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              BUT_STROB,
    input  logic              LAY_EN,
    input  logic              ADDR_EN,
    input  logic              Wr,
    input  logic              FIRST,
    output logic [LAYERS-1:0] RD_ADDR_A,
    output logic [LAYERS-1:0] RD_ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic              RD_VALID,
    output logic              RD_STROB,
    output logic [LAYERS-1:0] WR_ADDR_A,
    output logic [LAYERS-1:0] WR_ADDR_B,
    output logic              WR_EN,
    output logic              DONE,
    output logic              ERR
);

    localparam int c_UNUSED_W = 3 * 32 - 2 * LAYERS - ButtWL;

    logic [LayWL-1:0]    r_lay_cnt;
    logic [ButtWL-1:0]   r_but_cnt;
    bfly_addr_t          w_addr;
    logic [LAYERS-1:0]   w_a;
    logic [LAYERS-1:0]   w_b;
    logic [ButtWL-1:0]   w_tw;
    logic [c_UNUSED_W-1:0] w_unused_bits;
    logic                w_issue;
    logic                w_advance;
    logic                w_last_lay;
    logic                w_last_but;
    logic                w_tail_valid;
    logic [2*LAYERS-1:0] w_tail_data;

    // Butterfly addresses for the current counters, truncated to port widths
    always_comb begin
        w_addr        = bfly_addr(32'(r_lay_cnt), 32'(r_but_cnt), 32'(LAYERS));
        w_a           = w_addr.a[LAYERS-1:0];
        w_b           = w_addr.b[LAYERS-1:0];
        w_tw          = w_addr.tw[ButtWL-1:0];
        w_unused_bits = {w_addr.a[31:LAYERS], w_addr.b[31:LAYERS], w_addr.tw[31:ButtWL]};
    end

    // FIRST swallows any same-cycle ADDR_EN / LAY_EN
    assign w_issue    = ADDR_EN & ~FIRST;
    assign w_advance  = LAY_EN & ~FIRST;
    assign w_last_lay = (r_lay_cnt == LayWL'(LAYERS - 1));
    assign w_last_but = (r_but_cnt == ButtWL'(BUTTERFLYES - 1));

    // Layer/butterfly counters; LAY_EN overrides the butterfly increment
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lay_cnt <= '0;
            r_but_cnt <= '0;
        end else if (EN) begin
            if (FIRST) begin
                r_lay_cnt <= '0;
                r_but_cnt <= '0;
            end else if (LAY_EN) begin
                r_but_cnt <= '0;
                r_lay_cnt <= w_last_lay ? '0 : r_lay_cnt + 1'b1;
            end else if (ADDR_EN) begin
                r_but_cnt <= w_last_but ? '0 : r_but_cnt + 1'b1;
            end
        end
    end

    // Read-side output registers, DONE pulse and sticky write-back error
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_ADDR_A <= '0;
            RD_ADDR_B <= '0;
            TW_ADDR   <= '0;
            RD_VALID  <= 1'b0;
            RD_STROB  <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else if (EN) begin
            RD_STROB <= BUT_STROB;
            RD_VALID <= w_issue;
            DONE     <= w_advance & w_last_lay;
            if (w_issue) begin
                RD_ADDR_A <= w_a;
                RD_ADDR_B <= w_b;
                TW_ADDR   <= w_tw;
            end
            if (FIRST) begin
                ERR <= 1'b0;
            end else if (Wr && !w_tail_valid) begin
                ERR <= 1'b1;
            end
        end
    end

    fft_addr_delay_line #(
        .DEPTH  (BUT_LATENCY),
        .DATA_W (2 * LAYERS)
    ) u_delay (
        .clk       (CLK),
        .rst       (RST),
        .en        (EN),
        .clr       (FIRST),
        .in_valid  (ADDR_EN),
        .in_data   ({w_a, w_b}),
        .out_valid (w_tail_valid),
        .out_data  (w_tail_data)
    );

    assign WR_ADDR_A = w_tail_data[2*LAYERS-1:LAYERS];
    assign WR_ADDR_B = w_tail_data[LAYERS-1:0];
    assign WR_EN     = Wr & w_tail_valid;

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_iter_addr_gen
// Description : Self-checking bench for fft_iter_addr_gen against an
//               arithmetic reference model of the DIT address sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_iter_addr_gen;

    localparam int LAYERS = 5;
    localparam int BFLY   = 16;
    localparam int LAYWL  = 3;
    localparam int BUTTWL = 4;
    localparam int LAT    = 3;
    localparam int N      = 1 << LAYERS;

    logic CLK = 1'b0;
    logic RST, EN, BUT_STROB, LAY_EN, ADDR_EN, Wr, FIRST;
    logic [LAYERS-1:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [BUTTWL-1:0] TW_ADDR;
    logic RD_VALID, RD_STROB, WR_EN, DONE, ERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int a;
        int b;
    } ent_t;

    int   m_lay, m_but, m_rd_a, m_rd_b, m_tw;
    bit   m_rd_valid, m_rd_strob, m_done, m_err;
    ent_t m_pipe[$];

    fft_iter_addr_gen #(
        .LAYERS(LAYERS), .BUTTERFLYES(BFLY), .LayWL(LAYWL), .ButtWL(BUTTWL), .BUT_LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .BUT_STROB(BUT_STROB), .LAY_EN(LAY_EN),
        .ADDR_EN(ADDR_EN), .Wr(Wr), .FIRST(FIRST),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .TW_ADDR(TW_ADDR),
        .RD_VALID(RD_VALID), .RD_STROB(RD_STROB),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .WR_EN(WR_EN),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference: butterfly b of layer l pairs element b%span of group b/span
    // with its partner span higher; twiddle exponent scales by N/(2*span).
    function automatic int ref_a(input int l, input int b);
        int span = 1 << l;
        return (b / span) * 2 * span + (b % span);
    endfunction
    function automatic int ref_b(input int l, input int b);
        return ref_a(l, b) + (1 << l);
    endfunction
    function automatic int ref_tw(input int l, input int b);
        int span = 1 << l;
        return (b % span) * ((N / 2) / span);
    endfunction

    function automatic void model_clear_pipe();
        ent_t e;
        e.v = 1'b0; e.a = 0; e.b = 0;
        m_pipe.delete();
        for (int i = 0; i < LAT; i++) m_pipe.push_back(e);
    endfunction

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; FIRST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0;
        Wr = 1'b0; BUT_STROB = 1'b0;
        m_lay = 0; m_but = 0; m_rd_a = 0; m_rd_b = 0; m_tw = 0;
        m_rd_valid = 0; m_rd_strob = 0; m_done = 0; m_err = 0;
        model_clear_pipe();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Drive one clock cycle of inputs and advance the model by the same cycle
    task automatic tick(input bit en, input bit first, input bit addr_en, input bit lay_en, input bit wr);
        bit   strob;
        ent_t e;
        strob = 1'($urandom_range(0, 1));
        EN = en; FIRST = first; ADDR_EN = addr_en; LAY_EN = lay_en; Wr = wr; BUT_STROB = strob;
        if (en) begin
            m_rd_strob = strob;
            if (first) begin
                m_lay = 0; m_but = 0; m_rd_valid = 0; m_done = 0; m_err = 0;
                model_clear_pipe();
            end else begin
                if (wr && !m_pipe[LAT-1].v) m_err = 1;
                m_rd_valid = addr_en;
                e.v = addr_en;
                e.a = ref_a(m_lay, m_but);
                e.b = ref_b(m_lay, m_but);
                if (addr_en) begin
                    m_rd_a = e.a; m_rd_b = e.b; m_tw = ref_tw(m_lay, m_but);
                end
                m_pipe.push_front(e);
                void'(m_pipe.pop_back());
                m_done = lay_en && (m_lay == LAYERS - 1);
                if (lay_en) begin
                    m_but = 0;
                    m_lay = (m_lay + 1) % LAYERS;
                end else if (addr_en) begin
                    m_but = (m_but + 1) % BFLY;
                end
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR} !== '0) begin
            errors++;
            $display("FAIL reset_rd: got v=%0b a=%0d b=%0d tw=%0d, want all 0", RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR);
        end
        checks++;
        if ({RD_STROB, DONE, ERR} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got strob=%0b done=%0b err=%0b, want 0 0 0", RD_STROB, DONE, ERR);
        end
        Wr = 1'b1; #1;
        checks++;
        if (WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en: got %0b, want 0", WR_EN);
        end
        Wr = 1'b0;
    endtask

    task automatic test_first_addr();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        checks++;
        if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR} !== {1'b1, 5'd0, 5'd1, 4'd0}) begin
            errors++;
            $display("FAIL first_addr: got v=%0b a=%0d b=%0d tw=%0d, want v=1 a=0 b=1 tw=0", RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR);
        end
        checks++;
        if (RD_STROB !== m_rd_strob) begin
            errors++;
            $display("FAIL rd_strob: got %0b, want %0b", RD_STROB, m_rd_strob);
        end
        tick(1, 0, 0, 0, 0);
        checks++;
        if (RD_VALID !== 1'b0 || RD_ADDR_A !== 5'd0 || RD_ADDR_B !== 5'd1) begin
            errors++;
            $display("FAIL rd_hold: got v=%0b a=%0d b=%0d, want v=0 a=0 b=1", RD_VALID, RD_ADDR_A, RD_ADDR_B);
        end
    endtask

    task automatic test_walk();
        int ea [2] = '{5, 9};
        int eb [2] = '{7, 13};
        int et [2] = '{8, 4};
        int nb [2] = '{3, 5};
        tick(1, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick(1, 0, 0, 1, 0);
            repeat (nb[k]) tick(1, 0, 1, 0, 0);
            tick(1, 0, 1, 0, 0);
            checks++;
            if (RD_VALID !== 1'b1 || RD_ADDR_A !== LAYERS'(ea[k]) || RD_ADDR_B !== LAYERS'(eb[k]) || TW_ADDR !== BUTTWL'(et[k])) begin
                errors++;
                $display("FAIL walk_rd%0d: got a=%0d b=%0d tw=%0d v=%0b, want a=%0d b=%0d tw=%0d v=1",
                         k, RD_ADDR_A, RD_ADDR_B, TW_ADDR, RD_VALID, ea[k], eb[k], et[k]);
            end
            repeat (LAT - 1) tick(1, 0, 0, 0, 0);
            Wr = 1'b1; #1;
            checks++;
            if (WR_EN !== 1'b1 || WR_ADDR_A !== LAYERS'(ea[k]) || WR_ADDR_B !== LAYERS'(eb[k])) begin
                errors++;
                $display("FAIL walk_wr%0d: got en=%0b a=%0d b=%0d, want en=1 a=%0d b=%0d",
                         k, WR_EN, WR_ADDR_A, WR_ADDR_B, ea[k], eb[k]);
            end
            tick(1, 0, 0, 0, 1);
        end
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL walk_err: got %0b, want 0", ERR);
        end
    endtask

    task automatic test_full_transform();
        int  seen [N];
        int  bad;
        bit  wr;
        tick(1, 1, 0, 0, 0);
        for (int l = 0; l < LAYERS; l++) begin
            for (int i = 0; i < N; i++) seen[i] = 0;
            for (int b = 0; b < BFLY; b++) begin
                repeat ($urandom_range(0, 2)) tick(1, 0, 0, 0, 0);
                wr = m_pipe[LAT-1].v && ($urandom_range(0, 1) == 1);
                Wr = wr; #1;
                checks++;
                if (WR_EN !== wr || (wr && (WR_ADDR_A !== LAYERS'(m_pipe[LAT-1].a) || WR_ADDR_B !== LAYERS'(m_pipe[LAT-1].b)))) begin
                    errors++;
                    $display("FAIL full_wr l=%0d b=%0d: got en=%0b a=%0d b=%0d, want en=%0b a=%0d b=%0d",
                             l, b, WR_EN, WR_ADDR_A, WR_ADDR_B, wr, m_pipe[LAT-1].a, m_pipe[LAT-1].b);
                end
                tick(1, 0, 1, 0, wr);
                checks++;
                if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR, RD_STROB} !==
                    {m_rd_valid, LAYERS'(m_rd_a), LAYERS'(m_rd_b), BUTTWL'(m_tw), m_rd_strob}) begin
                    errors++;
                    $display("FAIL full_rd l=%0d b=%0d: got v=%0b a=%0d b=%0d tw=%0d s=%0b, want v=%0b a=%0d b=%0d tw=%0d s=%0b",
                             l, b, RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR, RD_STROB,
                             m_rd_valid, m_rd_a, m_rd_b, m_tw, m_rd_strob);
                end
                seen[RD_ADDR_A]++;
                seen[RD_ADDR_B]++;
            end
            checks++;
            if (l == LAYERS - 1 && (RD_ADDR_A !== 5'd15 || RD_ADDR_B !== 5'd31 || TW_ADDR !== 4'd15)) begin
                errors++;
                $display("FAIL last_pair: got a=%0d b=%0d tw=%0d, want a=15 b=31 tw=15", RD_ADDR_A, RD_ADDR_B, TW_ADDR);
            end
            bad = 0;
            for (int i = 0; i < N; i++) if (seen[i] != 1) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL coverage l=%0d: %0d addresses not read exactly once, want 0", l, bad);
            end
            tick(1, 0, 0, 1, 0);
            checks++;
            if (DONE !== (l == LAYERS - 1)) begin
                errors++;
                $display("FAIL done l=%0d: got %0b, want %0b", l, DONE, (l == LAYERS - 1));
            end
        end
        tick(1, 0, 0, 0, 0);
        checks++;
        if (DONE !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%0b err=%0b, want 0 0", DONE, ERR);
        end
    endtask

    task automatic test_simul_addr_lay();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        tick(1, 0, 0, 1, 0);
        repeat (BFLY - 1) tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 1, 0);
        checks++;
        if ({RD_ADDR_A, RD_ADDR_B, TW_ADDR} !== {5'd27, 5'd31, 4'd12} || m_rd_a != 27) begin
            errors++;
            $display("FAIL simul_old: got a=%0d b=%0d tw=%0d, want a=27 b=31 tw=12", RD_ADDR_A, RD_ADDR_B, TW_ADDR);
        end
        tick(1, 0, 1, 0, 0);
        checks++;
        if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR} !== {1'b1, 5'd0, 5'd8, 4'd0}) begin
            errors++;
            $display("FAIL simul_new: got v=%0b a=%0d b=%0d tw=%0d, want v=1 a=0 b=8 tw=0", RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR);
        end
    endtask

    task automatic test_err();
        tick(1, 1, 0, 0, 0);
        repeat (LAT) tick(1, 0, 0, 0, 0);
        Wr = 1'b1; #1;
        checks++;
        if (WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL err_wr_en: got %0b, want 0", WR_EN);
        end
        tick(1, 0, 0, 0, 1);
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %0b, want 1", ERR);
        end
        repeat (2) tick(1, 0, $urandom_range(0, 1) == 1, 0, 0);
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %0b, want 1", ERR);
        end
        tick(1, 1, 0, 0, 0);
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %0b, want 0", ERR);
        end
    endtask

    task automatic test_freeze_then_first();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        repeat (LAT + 1) tick(1, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
            checks++;
            if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR, RD_STROB, DONE, ERR, WR_ADDR_A, WR_ADDR_B} !==
                {m_rd_valid, LAYERS'(m_rd_a), LAYERS'(m_rd_b), BUTTWL'(m_tw), m_rd_strob, m_done, m_err,
                 LAYERS'(m_pipe[LAT-1].a), LAYERS'(m_pipe[LAT-1].b)}) begin
                errors++;
                $display("FAIL freeze%0d: got v=%0b a=%0d b=%0d tw=%0d wa=%0d wb=%0d, want v=%0b a=%0d b=%0d tw=%0d wa=%0d wb=%0d",
                         k, RD_VALID, RD_ADDR_A, RD_ADDR_B, TW_ADDR, WR_ADDR_A, WR_ADDR_B,
                         m_rd_valid, m_rd_a, m_rd_b, m_tw, m_pipe[LAT-1].a, m_pipe[LAT-1].b);
            end
        end
        tick(1, 1, 0, 0, 0);
        Wr = 1'b1; #1;
        checks++;
        if (WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL first_stale0: got WR_EN=%0b, want 0", WR_EN);
        end
        tick(1, 0, 1, 0, 1);
        checks++;
        if ({RD_VALID, RD_ADDR_A, RD_ADDR_B} !== {1'b1, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL first_restart: got v=%0b a=%0d b=%0d, want v=1 a=0 b=1", RD_VALID, RD_ADDR_A, RD_ADDR_B);
        end
        for (int k = 1; k < LAT; k++) begin
            Wr = 1'b1; #1;
            checks++;
            if (WR_EN !== m_pipe[LAT-1].v) begin
                errors++;
                $display("FAIL first_stale%0d: got WR_EN=%0b, want %0b", k, WR_EN, m_pipe[LAT-1].v);
            end
            tick(1, 0, 0, 0, 1);
        end
    endtask

    task automatic test_rst_mid();
        tick(1, 1, 0, 0, 0);
        repeat (2) tick(1, 0, 1, 0, 0);
        do_reset();
        Wr = 1'b1; #1;
        checks++;
        if ({RD_VALID, RD_ADDR_A, RD_ADDR_B, WR_EN, ERR} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got v=%0b a=%0d b=%0d wr_en=%0b err=%0b, want all 0", RD_VALID, RD_ADDR_A, RD_ADDR_B, WR_EN, ERR);
        end
        Wr = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; BUT_STROB = 1'b0; LAY_EN = 1'b0;
        ADDR_EN = 1'b0; Wr = 1'b0; FIRST = 1'b0;
        test_reset();
        test_first_addr();
        test_walk();
        test_full_transform();
        test_simul_addr_lay();
        test_err();
        test_freeze_then_first();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
